// File: rtl/reg_bank_8x32_pkg.sv
// Shared sizing constants for the 8x32 register bank, its read mux and decoders.
package reg_bank_8x32_pkg;

  localparam int          NUM_REGS      = 8;
  localparam int          ADDR_W        = 3;
  localparam int          WIDTH_DEF     = 32;
  localparam logic [31:0] RESET_VAL_DEF = 32'h0000_0000;

  // Registers that can be written or marked busy; r0 drops out when hardwired to zero.
  function automatic logic [NUM_REGS-1:0] live_mask(input bit zero_r0);
    live_mask = {NUM_REGS{1'b1}};
    if (zero_r0) live_mask[0] = 1'b0;
  endfunction

endpackage

// File: rtl/reg_bank_8x32_dec_3to8.sv
// 3-to-8 one-hot decoder gated by an enable; used for the write and issue ports.
module dec_3to8
  import reg_bank_8x32_pkg::*;
(
  input  logic              en,
  input  logic [ADDR_W-1:0] a,
  output logic [NUM_REGS-1:0] oh
);

  always_comb begin
    oh = '0;
    if (en) oh[a] = 1'b1;
  end

endmodule

// File: rtl/reg_bank_8x32.sv
// Eight-entry register bank with one write port, a busy scoreboard and a sticky WAW flag.
module reg_bank_8x32
  import reg_bank_8x32_pkg::*;
#(
  parameter int               WIDTH     = WIDTH_DEF,
  parameter bit               ZERO_R0   = 1'b0,
  parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(RESET_VAL_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [WIDTH-1:0]  wd,
  input  logic              iss,
  input  logic [ADDR_W-1:0] ia,
  output logic [WIDTH-1:0]  r0,
  output logic [WIDTH-1:0]  r1,
  output logic [WIDTH-1:0]  r2,
  output logic [WIDTH-1:0]  r3,
  output logic [WIDTH-1:0]  r4,
  output logic [WIDTH-1:0]  r5,
  output logic [WIDTH-1:0]  r6,
  output logic [WIDTH-1:0]  r7,
  output logic [NUM_REGS-1:0] busy,
  output logic              err
);

  localparam logic [NUM_REGS-1:0] LIVE = live_mask(ZERO_R0);

  logic [NUM_REGS-1:0] wr_dec, is_dec;
  logic [NUM_REGS-1:0] wr_oh, is_oh;
  logic [NUM_REGS-1:0] busy_nxt;
  logic                waw;
  logic [WIDTH-1:0]    regs [NUM_REGS];

  dec_3to8 u_dec_wr (.en(we),  .a(wa), .oh(wr_dec));
  dec_3to8 u_dec_is (.en(iss), .a(ia), .oh(is_dec));

  assign wr_oh = wr_dec & LIVE;
  assign is_oh = is_dec & LIVE;

  // A same-cycle write retires the old producer first, so a fresh issue
  // to that register is not a hazard and leaves the register busy again.
  always_comb begin
    busy_nxt = (busy & ~wr_oh) | is_oh;
    waw      = |(is_oh & busy & ~wr_oh);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
      err  <= 1'b0;
    end else begin
      busy <= busy_nxt;
      err  <= err | waw;
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_REGS; k++) begin
      if (rst)
        regs[k] <= (k == 0 && ZERO_R0) ? {WIDTH{1'b0}} : RESET_VAL;
      else if (wr_oh[k])
        regs[k] <= wd;
    end
  end

  assign r0 = regs[0];
  assign r1 = regs[1];
  assign r2 = regs[2];
  assign r3 = regs[3];
  assign r4 = regs[4];
  assign r5 = regs[5];
  assign r6 = regs[6];
  assign r7 = regs[7];

endmodule

// File: tb/tb_reg_bank_8x32.sv
// Directed bench for reg_bank_8x32: a default build and a ZERO_R0 build share stimulus.
module tb_reg_bank_8x32;

  logic        clk = 1'b0;
  logic        rst, we, iss;
  logic [2:0]  wa, ia;
  logic [31:0] wd;

  logic [31:0] d_r [8];
  logic [31:0] z_r [8];
  logic [7:0]  d_busy, z_busy;
  logic        d_err, z_err;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  reg_bank_8x32 #(.WIDTH(32), .ZERO_R0(1'b0), .RESET_VAL(32'h0)) dut (
    .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd), .iss(iss), .ia(ia),
    .r0(d_r[0]), .r1(d_r[1]), .r2(d_r[2]), .r3(d_r[3]),
    .r4(d_r[4]), .r5(d_r[5]), .r6(d_r[6]), .r7(d_r[7]),
    .busy(d_busy), .err(d_err)
  );

  reg_bank_8x32 #(.WIDTH(32), .ZERO_R0(1'b1), .RESET_VAL(32'h0)) dutz (
    .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd), .iss(iss), .ia(ia),
    .r0(z_r[0]), .r1(z_r[1]), .r2(z_r[2]), .r3(z_r[3]),
    .r4(z_r[4]), .r5(z_r[5]), .r6(z_r[6]), .r7(z_r[7]),
    .busy(z_busy), .err(z_err)
  );

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 1'b0; iss = 1'b0; rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; we = 1'b0; iss = 1'b0; wa = 3'd0; ia = 3'd0; wd = 32'h0;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      for (int k = 0; k < 8; k++) begin
        n_chk++;
        if (d_r[k] !== 32'h0) begin
          n_fail++; $display("FAIL reset_r%0d cyc%0d: got %h want %h", k, c, d_r[k], 32'h0);
        end
      end
      n_chk++;
      if (d_busy !== 8'h00) begin
        n_fail++; $display("FAIL reset_busy cyc%0d: got %h want %h", c, d_busy, 8'h00);
      end
      n_chk++;
      if (d_err !== 1'b0) begin
        n_fail++; $display("FAIL reset_err cyc%0d: got %b want 0", c, d_err);
      end
      tick();
    end
  endtask

  task automatic test_write_latency();
    we = 1'b1; wa = 3'd3; wd = 32'hDEADBEEF;
    #1;
    n_chk++;
    if (d_r[3] !== 32'h0) begin
      n_fail++; $display("FAIL write_no_bypass: got %h want %h", d_r[3], 32'h0);
    end
    tick();
    idle();
    for (int c = 0; c < 2; c++) begin
      for (int k = 0; k < 8; k++) begin
        n_chk++;
        if (d_r[k] !== ((k == 3) ? 32'hDEADBEEF : 32'h0)) begin
          n_fail++; $display("FAIL write_r%0d cyc%0d: got %h want %h", k, c, d_r[k],
                             (k == 3) ? 32'hDEADBEEF : 32'h0);
        end
      end
      n_chk++;
      if (d_busy !== 8'h00) begin
        n_fail++; $display("FAIL write_busy cyc%0d: got %h want %h", c, d_busy, 8'h00);
      end
      tick();
    end
  endtask

  task automatic test_scoreboard();
    iss = 1'b1; ia = 3'd5;
    tick();
    idle();
    n_chk++;
    if (d_busy !== 8'h20) begin
      n_fail++; $display("FAIL sb_issue_busy: got %h want %h", d_busy, 8'h20);
    end
    tick(); tick();
    n_chk++;
    if (d_busy !== 8'h20) begin
      n_fail++; $display("FAIL sb_hold_busy: got %h want %h", d_busy, 8'h20);
    end
    we = 1'b1; wa = 3'd5; wd = 32'h12345678;
    tick();
    idle();
    n_chk++;
    if (d_busy !== 8'h00) begin
      n_fail++; $display("FAIL sb_wb_busy: got %h want %h", d_busy, 8'h00);
    end
    n_chk++;
    if (d_r[5] !== 32'h12345678) begin
      n_fail++; $display("FAIL sb_wb_r5: got %h want %h", d_r[5], 32'h12345678);
    end
    n_chk++;
    if (d_err !== 1'b0) begin
      n_fail++; $display("FAIL sb_err: got %b want 0", d_err);
    end
  endtask

  task automatic test_waw();
    iss = 1'b1; ia = 3'd2;
    tick();
    n_chk++;
    if (d_err !== 1'b0) begin
      n_fail++; $display("FAIL waw_first_issue_err: got %b want 0", d_err);
    end
    tick();
    idle();
    n_chk++;
    if (d_err !== 1'b1) begin
      n_fail++; $display("FAIL waw_err_set: got %b want 1", d_err);
    end
    n_chk++;
    if (d_busy !== 8'h04) begin
      n_fail++; $display("FAIL waw_busy: got %h want %h", d_busy, 8'h04);
    end
    we = 1'b1; wa = 3'd2; wd = 32'h0BAD0BAD;
    tick();
    idle();
    tick();
    n_chk++;
    if (d_err !== 1'b1) begin
      n_fail++; $display("FAIL waw_err_sticky: got %b want 1", d_err);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_chk++;
    if (d_err !== 1'b0 || d_busy !== 8'h00) begin
      n_fail++; $display("FAIL waw_reset_clear: got err=%b busy=%h want err=0 busy=00", d_err, d_busy);
    end
  endtask

  task automatic test_simul_same();
    iss = 1'b1; ia = 3'd6;
    tick();
    we = 1'b1; wa = 3'd6; wd = 32'hCAFEF00D;
    tick();
    idle();
    n_chk++;
    if (d_err !== 1'b0) begin
      n_fail++; $display("FAIL same_err: got %b want 0", d_err);
    end
    n_chk++;
    if (d_busy !== 8'h40) begin
      n_fail++; $display("FAIL same_busy: got %h want %h", d_busy, 8'h40);
    end
    n_chk++;
    if (d_r[6] !== 32'hCAFEF00D) begin
      n_fail++; $display("FAIL same_r6: got %h want %h", d_r[6], 32'hCAFEF00D);
    end
  endtask

  task automatic test_simul_diff();
    iss = 1'b1; ia = 3'd1; we = 1'b1; wa = 3'd6; wd = 32'h11112222;
    tick();
    idle();
    n_chk++;
    if (d_busy !== 8'h02) begin
      n_fail++; $display("FAIL diff_busy: got %h want %h", d_busy, 8'h02);
    end
    n_chk++;
    if (d_r[6] !== 32'h11112222 || d_r[1] !== 32'h0) begin
      n_fail++; $display("FAIL diff_data: got r6=%h r1=%h want r6=11112222 r1=00000000", d_r[6], d_r[1]);
    end
    n_chk++;
    if (d_err !== 1'b0) begin
      n_fail++; $display("FAIL diff_err: got %b want 0", d_err);
    end
    we = 1'b1; wa = 3'd1; wd = 32'h33334444;
    tick();
    idle();
    n_chk++;
    if (d_busy !== 8'h00 || d_r[1] !== 32'h33334444) begin
      n_fail++; $display("FAIL diff_wb: got busy=%h r1=%h want busy=00 r1=33334444", d_busy, d_r[1]);
    end
  endtask

  task automatic test_zero_r0();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    we = 1'b1; wa = 3'd0; wd = 32'hFFFFFFFF; iss = 1'b1; ia = 3'd0;
    tick();
    idle();
    n_chk++;
    if (z_r[0] !== 32'h0) begin
      n_fail++; $display("FAIL zr0_r0: got %h want %h", z_r[0], 32'h0);
    end
    n_chk++;
    if (z_busy !== 8'h00 || z_err !== 1'b0) begin
      n_fail++; $display("FAIL zr0_busy_err: got busy=%h err=%b want busy=00 err=0", z_busy, z_err);
    end
    n_chk++;
    if (d_r[0] !== 32'hFFFFFFFF || d_busy !== 8'h01) begin
      n_fail++; $display("FAIL nz_r0: got r0=%h busy=%h want r0=ffffffff busy=01", d_r[0], d_busy);
    end
    iss = 1'b1; ia = 3'd0;
    tick();
    idle();
    n_chk++;
    if (z_err !== 1'b0 || z_busy !== 8'h00) begin
      n_fail++; $display("FAIL zr0_reissue: got err=%b busy=%h want err=0 busy=00", z_err, z_busy);
    end
    n_chk++;
    if (d_err !== 1'b1) begin
      n_fail++; $display("FAIL nz_reissue_err: got %b want 1", d_err);
    end
    we = 1'b1; wa = 3'd4; wd = 32'h44440000;
    tick();
    idle();
    n_chk++;
    if (z_r[4] !== 32'h44440000) begin
      n_fail++; $display("FAIL zr0_r4: got %h want %h", z_r[4], 32'h44440000);
    end
  endtask

  task automatic test_reset_priority();
    we = 1'b1; wa = 3'd1; wd = 32'h55555555;
    tick();
    idle();
    rst = 1'b1; we = 1'b1; wa = 3'd1; wd = 32'hA5A5A5A5; iss = 1'b1; ia = 3'd1;
    tick();
    idle();
    n_chk++;
    if (d_r[1] !== 32'h0) begin
      n_fail++; $display("FAIL rstprio_r1: got %h want %h", d_r[1], 32'h0);
    end
    n_chk++;
    if (d_busy !== 8'h00 || d_err !== 1'b0) begin
      n_fail++; $display("FAIL rstprio_busy_err: got busy=%h err=%b want busy=00 err=0", d_busy, d_err);
    end
    n_chk++;
    if (d_r[0] !== 32'h0 || d_r[4] !== 32'h0) begin
      n_fail++; $display("FAIL rstprio_all: got r0=%h r4=%h want 0", d_r[0], d_r[4]);
    end
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; iss = 1'b0; wa = 3'd0; ia = 3'd0; wd = 32'h0;
    test_reset();
    test_write_latency();
    test_scoreboard();
    test_waw();
    test_simul_same();
    test_simul_diff();
    test_zero_r0();
    test_reset_priority();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
